pixel_frame_sequencer: RTL and testbench
========================================

Name: pixel_frame_sequencer

Overview:
- Frame-level controller for the 2x2 pixel array, its ramp ADC and its gray counter.
- Sequences the ERASE, EXPOSE, CONVERT and READ phases using programmable per-frame durations.
- Captures each row's 16-bit pixel data and hands it to the downstream databus over a valid/ready handshake, stalling the read phase under backpressure.
- Sits between the top-level frame trigger and the PIXEL_ARRAY, GRAYCOUNTER and DATABUS instances.

Parameters:
- CNT_W, 16, width of phase duration counters and of the cfg_* duration inputs.
- READ_SETUP, 2, cycles read1/read2 is held before row data is sampled (min 1).
- DATA_W, 16, width of one row word (two 8-bit pixels).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled in IDLE to begin a frame.
- continuous  input  1  when 1, a new frame starts immediately after frame_done without start.
- cfg_erase  input  CNT_W  ERASE duration in cycles.
- cfg_expose  input  CNT_W  EXPOSE duration in cycles.
- cfg_convert  input  CNT_W  CONVERT duration in cycles.
- row1_data  input  DATA_W  {DATA11,DATA12} from the array.
- row2_data  input  DATA_W  {DATA21,DATA22} from the array.
- out_ready  input  1  downstream accepts out_data.
- erase  output  1  array erase strobe.
- expose  output  1  array expose strobe.
- convert  output  1  ramp/gray-counter enable.
- read1  output  1  row 1 read enable.
- read2  output  1  row 2 read enable.
- out_data  output  DATA_W  captured row word.
- out_row  output  1  0 = row 1, 1 = row 2; valid with out_valid.
- out_valid  output  1  out_data valid.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse at end of READ2 handshake.

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. out_data=0, counter=0, config shadow registers=0.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ1, WAIT1, READ2, WAIT2.
- IDLE: when start=1, latch cfg_* into shadow registers. Load counter with max(cfg_erase,1)-1 and go to ERASE next cycle. cfg_* changes mid-frame have no effect.
- Duration rule: a cfg value of 0 is treated as 1. Each timed phase lasts exactly max(cfg,1) cycles.
- Timed phases: the counter decrements each cycle. At counter==0, move to the next phase and reload the counter for that phase.
  - ERASE then EXPOSE, with erase=1 throughout ERASE.
  - EXPOSE then CONVERT, with expose=1 throughout EXPOSE.
  - CONVERT then READ1, with convert=1 throughout CONVERT.
- Strobe timing: strobes are registered and high for exactly the cycles the FSM is in the matching state. No overlap between any two of erase, expose, convert, read1, read2.
- READ1: read1=1 for READ_SETUP cycles. On the last setup cycle, capture row1_data into out_data, set out_row=0 and out_valid=1 (registered, visible the next cycle), then go to WAIT1.
- WAIT1: read1 stays 1 and out_valid stays 1. out_data and out_row are stable.
  - out_valid=1 with out_ready=1 is a transfer. On transfer: out_valid=0 next cycle, go to READ2.
  - Stalls of any length are allowed.
- READ2/WAIT2: identical to READ1/WAIT1, using read2 and row2_data, with out_row=1.
- End of frame: the WAIT2 transfer pulses frame_done=1 for one cycle (the cycle after the transfer).
  - The FSM then goes to IDLE.
  - If continuous=1 at the transfer cycle, or start=1, it instead goes directly to ERASE, re-latching cfg_* in that same transition.
- Handshake constraints: out_ready is ignored when out_valid=0. out_valid never drops without a transfer, except on reset.
- busy: 1 from the first ERASE cycle through the frame_done cycle inclusive, then 0 in IDLE.
- Reset mid-operation: immediate return to IDLE with all strobes low. Any pending out_valid is dropped and no frame_done is issued.
- Maximum duration: the counter is CNT_W wide with no wrap. cfg=2^CNT_W-1 yields exactly that many cycles.

Test Plan:
- Basic frame: cfg_erase=5, cfg_expose=255, cfg_convert=255, out_ready=1, pulse start.
  - Required: erase high exactly 5 cycles, expose 255, convert 255, read1 READ_SETUP+1 cycles.
  - Required: out_data=row1_data with out_row=0, then row2_data with out_row=1.
  - Required: frame_done single pulse, busy low afterward.
- Backpressure: out_ready=0 for 20 cycles in WAIT1.
  - Required: out_valid, out_data and read1 held stable for all 20 cycles; read2 not asserted.
  - Required: transfer on the first cycle with out_ready=1.
- Zero config: cfg_erase=0, cfg_expose=0, cfg_convert=0.
  - Required: each phase lasts exactly 1 cycle; frame completes normally.
- Continuous mode: continuous=1, 3 frames.
  - Required: ERASE begins the cycle after each WAIT2 transfer with no IDLE gap.
  - Required: cfg change mid-frame is applied only at the next frame.
- Async reset mid-EXPOSE and mid-WAIT2 (reset low between clock edges).
  - Required: all outputs 0 immediately, no frame_done, state IDLE.
  - Required: a new start after release runs a full correct frame.
- Strobe exclusivity: assertion over all frames that at most one of erase, expose, convert, read1, read2 is high, and that each out_valid rise is followed by exactly one transfer.

Source files
------------

// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer for the 2x2 pixel array: timed ERASE/EXPOSE/CONVERT phases, then two row reads handed out over valid/ready.
// Strobes and out_* are registered; the READ phases stall in WAIT1/WAIT2 for as long as out_ready stays low.
module pixel_frame_sequencer #(
    parameter int CNT_W      = 16,
    parameter int READ_SETUP = 2,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic [CNT_W-1:0]  cfg_erase,
    input  logic [CNT_W-1:0]  cfg_expose,
    input  logic [CNT_W-1:0]  cfg_convert,
    input  logic [DATA_W-1:0] row1_data,
    input  logic [DATA_W-1:0] row2_data,
    input  logic              out_ready,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic              read1,
    output logic              read2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_row,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_READ1   = 3'd4;
    localparam logic [2:0] S_WAIT1   = 3'd5;
    localparam logic [2:0] S_READ2   = 3'd6;
    localparam logic [2:0] S_WAIT2   = 3'd7;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(READ_SETUP - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  sh_expose_q, sh_expose_d;
    logic [CNT_W-1:0]  sh_convert_q, sh_convert_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_row_q, out_row_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic [4:0]        strobe_q, strobe_d;
    logic              xfer;

    // A zero duration still occupies one cycle, so the reload value saturates at 0.
    function automatic logic [CNT_W-1:0] dur_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    assign xfer = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_expose_d  = sh_expose_q;
        sh_convert_d = sh_convert_q;
        out_data_d   = out_data_q;
        out_row_d    = out_row_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // The erase duration is consumed straight into the counter, so it needs no shadow.
                    sh_expose_d  = cfg_expose;
                    sh_convert_d = cfg_convert;
                    cnt_d        = dur_m1(cfg_erase);
                    state_d      = S_ERASE;
                end
            end
            S_ERASE: begin
                if (cnt_q == '0) begin
                    cnt_d   = dur_m1(sh_expose_q);
                    state_d = S_EXPOSE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_EXPOSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = dur_m1(sh_convert_q);
                    state_d = S_CONVERT;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_CONVERT: begin
                if (cnt_q == '0) begin
                    cnt_d   = SETUP_M1;
                    state_d = S_READ1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_READ1: begin
                if (cnt_q == '0) begin
                    out_data_d  = row1_data;
                    out_row_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_WAIT1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_WAIT1: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    cnt_d       = SETUP_M1;
                    state_d     = S_READ2;
                end
            end
            S_READ2: begin
                if (cnt_q == '0) begin
                    out_data_d  = row2_data;
                    out_row_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_WAIT2;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_WAIT2: begin
                if (xfer) begin
                    out_valid_d  = 1'b0;
                    frame_done_d = 1'b1;
                    if (continuous || start) begin
                        sh_expose_d  = cfg_expose;
                        sh_convert_d = cfg_convert;
                        cnt_d        = dur_m1(cfg_erase);
                        state_d      = S_ERASE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes follow the next state so each flop is high exactly while the FSM sits in its phase.
        strobe_d = {(state_d == S_READ2) || (state_d == S_WAIT2),
                    (state_d == S_READ1) || (state_d == S_WAIT1),
                    (state_d == S_CONVERT),
                    (state_d == S_EXPOSE),
                    (state_d == S_ERASE)};
        busy_d   = (state_d != S_IDLE) || frame_done_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sh_expose_q  <= '0;
            sh_convert_q <= '0;
            out_data_q   <= '0;
            out_row_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            strobe_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_expose_q  <= sh_expose_d;
            sh_convert_q <= sh_convert_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            strobe_q     <= strobe_d;
        end
    end

    assign erase      = strobe_q[0];
    assign expose     = strobe_q[1];
    assign convert    = strobe_q[2];
    assign read1      = strobe_q[3];
    assign read2      = strobe_q[4];
    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer: row words go through a scoreboard, phase lengths come from a strobe monitor.
`timescale 1ns/1ps
module tb_pixel_frame_sequencer;
    localparam int CNT_W      = 16;
    localparam int READ_SETUP = 2;
    localparam int DATA_W     = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  cfg_erase = '0;
    logic [CNT_W-1:0]  cfg_expose = '0;
    logic [CNT_W-1:0]  cfg_convert = '0;
    logic [DATA_W-1:0] row1_data = '0;
    logic [DATA_W-1:0] row2_data = '0;
    logic              erase, expose, convert, read1, read2;
    logic              out_row, out_valid, busy, frame_done;
    logic [DATA_W-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic              row;
        logic [DATA_W-1:0] dat;
    } exp_t;
    exp_t sb[$];

    int run_len[5];
    int last_len[5];
    int fd_cnt = 0;
    int stall_cnt = 0;
    logic              pv_vld = 1'b0, pv_xfer = 1'b0, pv_row = 1'b0, pv_fd = 1'b0;
    logic [DATA_W-1:0] pv_dat = '0;

    pixel_frame_sequencer #(.CNT_W(CNT_W), .READ_SETUP(READ_SETUP), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .cfg_erase(cfg_erase), .cfg_expose(cfg_expose), .cfg_convert(cfg_convert),
        .row1_data(row1_data), .row2_data(row2_data), .out_ready(out_ready),
        .erase(erase), .expose(expose), .convert(convert), .read1(read1), .read2(read2),
        .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // Monitor sampled on the falling edge; inputs only change just after a rising edge.
    always @(negedge clk) begin : mon
        logic [4:0] s;
        exp_t e;
        s = {read2, read1, convert, expose, erase};
        if (!reset) begin
            pv_vld = 1'b0; pv_xfer = 1'b0; pv_fd = 1'b0;
            for (int i = 0; i < 5; i++) run_len[i] = 0;
        end else begin
            n_vec++;
            if ($countones(s) > 1) begin
                n_err++; $display("FAIL strobe_excl got %b want at most one high", s);
            end
            for (int i = 0; i < 5; i++) begin
                if (s[i]) run_len[i]++;
                else if (run_len[i] != 0) begin last_len[i] = run_len[i]; run_len[i] = 0; end
            end
            if (pv_vld && !pv_xfer) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== pv_dat || out_row !== pv_row) begin
                    n_err++;
                    $display("FAIL hold got v=%b d=%h r=%b want v=1 d=%h r=%b", out_valid, out_data, out_row, pv_dat, pv_row);
                end
            end
            if (pv_xfer) begin
                n_vec++;
                if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_xfer_valid got %b want 0", out_valid); end
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL sb_unexpected got d=%h r=%b want no transfer", out_data, out_row);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.dat || out_row !== e.row) begin
                        n_err++; $display("FAIL sb_data got d=%h r=%b want d=%h r=%b", out_data, out_row, e.dat, e.row);
                    end
                end
            end
            if (frame_done) begin
                fd_cnt++; n_vec++;
                if (pv_fd !== 1'b0) begin n_err++; $display("FAIL fd_width got 2+ cycles want 1"); end
            end
            pv_vld = out_valid; pv_xfer = out_valid && out_ready;
            pv_dat = out_data;  pv_row = out_row; pv_fd = frame_done;
        end
    end

    task automatic wait_cond(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            case (sel)
                0: ok = frame_done;
                1: ok = out_valid;
                2: ok = expose;
                3: ok = read2;
                default: ok = 1'b0;
            endcase
            if (ok) break;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic setup_frame(input int e, input int x, input int c, input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2);
        cfg_erase = CNT_W'(e); cfg_expose = CNT_W'(x); cfg_convert = CNT_W'(c);
        row1_data = r1; row2_data = r2;
        sb.push_back('{row: 1'b0, dat: r1});
        sb.push_back('{row: 1'b1, dat: r2});
    endtask

    task automatic test_reset();
        @(posedge clk); #2; reset = 1'b0; #1;
        n_vec++;
        if ({erase, expose, convert, read1, read2, out_valid, out_row, busy, frame_done} !== 9'd0 || out_data !== '0) begin
            n_err++; $display("FAIL reset_async got outs=%b d=%h want 0", {erase, expose, convert, read1, read2, out_valid, out_row, busy, frame_done}, out_data);
        end
        repeat (3) @(posedge clk);
        #1; reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({erase, expose, convert, read1, read2, out_valid, busy, frame_done} !== 8'd0) begin
            n_err++; $display("FAIL reset_idle got %b want 0", {erase, expose, convert, read1, read2, out_valid, busy, frame_done});
        end
    endtask

    task automatic test_basic();
        bit ok; int fd0;
        fd0 = fd_cnt; out_ready = 1'b1;
        setup_frame(5, 255, 255, 16'hA1B2, 16'hC3D4);
        pulse_start();
        @(negedge clk); #1;
        n_vec++;
        if (erase !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL basic_first got erase=%b busy=%b want 1 1", erase, busy); end
        wait_cond(0, 2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_fd got timeout want frame_done"); end
        n_vec++; if (last_len[0] != 5) begin n_err++; $display("FAIL basic_erase_len got %0d want 5", last_len[0]); end
        n_vec++; if (last_len[1] != 255) begin n_err++; $display("FAIL basic_expose_len got %0d want 255", last_len[1]); end
        n_vec++; if (last_len[2] != 255) begin n_err++; $display("FAIL basic_convert_len got %0d want 255", last_len[2]); end
        n_vec++; if (last_len[3] != READ_SETUP + 1) begin n_err++; $display("FAIL basic_read1_len got %0d want %0d", last_len[3], READ_SETUP + 1); end
        n_vec++; if (last_len[4] != READ_SETUP + 1) begin n_err++; $display("FAIL basic_read2_len got %0d want %0d", last_len[4], READ_SETUP + 1); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_fd got %b want 1", busy); end
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0 || frame_done !== 1'b0 || erase !== 1'b0) begin
            n_err++; $display("FAIL basic_after got busy=%b fd=%b erase=%b want 0 0 0", busy, frame_done, erase);
        end
        n_vec++; if (fd_cnt - fd0 != 1 || sb.size() != 0) begin
            n_err++; $display("FAIL basic_count got fd=%0d sb=%0d want 1 0", fd_cnt - fd0, sb.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok; int s0;
        out_ready = 1'b0; s0 = stall_cnt;
        setup_frame(3, 4, 5, 16'h1111, 16'h2222);
        pulse_start();
        wait_cond(1, 200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_valid got timeout want out_valid"); end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            n_vec++;
            if (out_valid !== 1'b1 || read1 !== 1'b1 || read2 !== 1'b0 || out_data !== 16'h1111 || out_row !== 1'b0) begin
                n_err++; $display("FAIL bp_stall[%0d] got v=%b r1=%b r2=%b d=%h want 1 1 0 1111", i, out_valid, read1, read2, out_data);
            end
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_vec++; if (out_valid !== 1'b0 || read2 !== 1'b1 || read1 !== 1'b0) begin
            n_err++; $display("FAIL bp_release got v=%b r1=%b r2=%b want 0 0 1", out_valid, read1, read2);
        end
        n_vec++; if (stall_cnt - s0 != 20) begin n_err++; $display("FAIL bp_stall_cnt got %0d want 20", stall_cnt - s0); end
        wait_cond(0, 200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_fd got timeout want frame_done"); end
        n_vec++; if (last_len[3] != READ_SETUP + 21) begin n_err++; $display("FAIL bp_read1_len got %0d want %0d", last_len[3], READ_SETUP + 21); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL bp_sb got %0d want 0", sb.size()); end
    endtask

    task automatic test_zero_cfg();
        bit ok;
        setup_frame(0, 0, 0, 16'h0F0F, 16'hF0F0);
        pulse_start();
        wait_cond(0, 100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL zero_fd got timeout want frame_done"); end
        n_vec++; if (last_len[0] != 1 || last_len[1] != 1 || last_len[2] != 1) begin
            n_err++; $display("FAIL zero_len got %0d/%0d/%0d want 1/1/1", last_len[0], last_len[1], last_len[2]);
        end
        n_vec++; if (last_len[3] != READ_SETUP + 1 || last_len[4] != READ_SETUP + 1) begin
            n_err++; $display("FAIL zero_read_len got %0d/%0d want %0d", last_len[3], last_len[4], READ_SETUP + 1);
        end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL zero_sb got %0d want 0", sb.size()); end
    endtask

    task automatic test_continuous();
        bit ok;
        int exp_x[3] = '{10, 20, 30};
        continuous = 1'b1;
        setup_frame(3, 10, 4, 16'h1001, 16'h2001);
        pulse_start();
        cfg_expose = CNT_W'(20);
        for (int f = 0; f < 3; f++) begin
            wait_cond(0, 300, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL cont_fd[%0d] got timeout want frame_done", f); end
            n_vec++; if (last_len[0] != 3 || last_len[1] != exp_x[f]) begin
                n_err++; $display("FAIL cont_len[%0d] got erase=%0d expose=%0d want 3 %0d", f, last_len[0], last_len[1], exp_x[f]);
            end
            n_vec++;
            if (f < 2) begin
                if (erase !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL cont_gap[%0d] got erase=%b busy=%b want 1 1", f, erase, busy); end
            end else begin
                if (erase !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL cont_end got erase=%b busy=%b want 0 1", erase, busy); end
            end
            @(posedge clk); #1;
            if (f == 0) cfg_expose = CNT_W'(30);
            if (f == 1) continuous = 1'b0;
            if (f < 2) begin
                row1_data = 16'h1002 + DATA_W'(f); row2_data = 16'h2002 + DATA_W'(f);
                sb.push_back('{row: 1'b0, dat: row1_data});
                sb.push_back('{row: 1'b1, dat: row2_data});
            end
        end
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0 || sb.size() != 0) begin
            n_err++; $display("FAIL cont_idle got busy=%b sb=%0d want 0 0", busy, sb.size());
        end
    endtask

    task automatic test_async_reset();
        bit ok; int fd0;
        for (int part = 0; part < 2; part++) begin
            out_ready = 1'b1;
            if (part == 0) begin
                setup_frame(4, 50, 4, 16'h5A5A, 16'hA5A5);
                pulse_start();
                wait_cond(2, 100, ok);
                repeat (10) @(posedge clk);
            end else begin
                setup_frame(2, 3, 2, 16'h3C3C, 16'hC3C3);
                pulse_start();
                wait_cond(3, 100, ok);
                @(posedge clk); #1; out_ready = 1'b0;
                if (ok) wait_cond(1, 20, ok);
                repeat (5) @(posedge clk);
            end
            n_vec++; if (!ok) begin n_err++; $display("FAIL rst_reach[%0d] got timeout want target phase", part); end
            #2; reset = 1'b0; #1;
            fd0 = fd_cnt;
            n_vec++;
            if ({erase, expose, convert, read1, read2, out_valid, out_row, busy, frame_done} !== 9'd0 || out_data !== '0) begin
                n_err++; $display("FAIL rst_mid[%0d] got outs=%b d=%h want 0", part, {erase, expose, convert, read1, read2, out_valid, out_row, busy, frame_done}, out_data);
            end
            sb.delete();
            repeat (3) @(posedge clk);
            #1; reset = 1'b1; out_ready = 1'b1;
            repeat (20) @(negedge clk);
            #1;
            n_vec++; if (fd_cnt != fd0 || busy !== 1'b0 || erase !== 1'b0 || out_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_idle[%0d] got fd=%0d busy=%b erase=%b v=%b want 0", part, fd_cnt - fd0, busy, erase, out_valid);
            end
        end
        setup_frame(6, 7, 8, 16'h7E57, 16'hBEEF);
        pulse_start();
        wait_cond(0, 200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rst_frame_fd got timeout want frame_done"); end
        n_vec++; if (last_len[0] != 6 || last_len[1] != 7 || last_len[2] != 8 || last_len[3] != 3 || last_len[4] != 3) begin
            n_err++; $display("FAIL rst_frame_len got %0d/%0d/%0d/%0d/%0d want 6/7/8/3/3", last_len[0], last_len[1], last_len[2], last_len[3], last_len[4]);
        end
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0 || sb.size() != 0) begin
            n_err++; $display("FAIL rst_frame_end got busy=%b sb=%0d want 0 0", busy, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_cfg();
        test_continuous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
